// File: rtl/cvxif_offload_master_if.sv
// CV-X-IF issue and result channels between the CPU-side offload master and
// the MAC4B coprocessor.
//   master modport : drives the issue request and the result ready
//   slave  modport : drives issue ready/response and the result channel
interface cvxif_offload_master_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned IdWidth = 3
);
   // issue channel
   logic                x_issue_valid;
   logic                x_issue_ready;
   logic [31:0]         x_issue_instr;
   logic [2*XLEN-1:0]   x_issue_rs;        // {rs2,rs1}
   logic [1:0]          x_issue_rs_valid;  // {rs2,rs1}
   logic [IdWidth-1:0]  x_issue_id;
   logic                x_issue_accept;
   logic                x_issue_writeback;
   // result channel
   logic                x_result_valid;
   logic                x_result_ready;
   logic [IdWidth-1:0]  x_result_id;
   logic [XLEN-1:0]     x_result_data;
   logic [4:0]          x_result_rd;
   logic                x_result_we;
   logic                x_result_exc;

   modport master (
      output x_issue_valid, x_issue_instr, x_issue_rs, x_issue_rs_valid, x_issue_id,
      input  x_issue_ready, x_issue_accept, x_issue_writeback,
      input  x_result_valid, x_result_id, x_result_data, x_result_rd, x_result_we,
             x_result_exc,
      output x_result_ready
   );

   modport slave (
      input  x_issue_valid, x_issue_instr, x_issue_rs, x_issue_rs_valid, x_issue_id,
      output x_issue_ready, x_issue_accept, x_issue_writeback,
      output x_result_valid, x_result_id, x_result_data, x_result_rd, x_result_we,
             x_result_exc,
      input  x_result_ready
   );
endinterface

// File: rtl/cvxif_offload_master.sv
// CPU-side CV-X-IF initiator for the MAC4B coprocessor.
// Takes offloaded instructions from the core, issues them with operands and a
// transaction ID, tracks IDs that promised a writeback, forwards results to
// the core writeback port and flags rejected or unmatched traffic.
// Ports:
//   clk_i, rst_ni          clock / async active-low reset
//   instr_*, rs*_i         core offload request (valid/ready)
//   xif (master)           X-interface issue + result channels
//   wb_*                   result forwarded to the core (valid/ready)
//   illegal_o, spurious_o  one-cycle pulses: issue rejected / result dropped
//   busy_o                 issue in flight or any ID pending
// The interface instance must use the same XLEN/IdWidth as this module.
module cvxif_offload_master #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned IdWidth        = 3,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic [31:0]           instr_i,
   input  logic [XLEN-1:0]       rs1_i,
   input  logic [XLEN-1:0]       rs2_i,
   input  logic [1:0]            rs_valid_i,
   cvxif_offload_master_if.master xif,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [XLEN-1:0]       wb_data_o,
   output logic [4:0]            wb_rd_o,
   output logic                  wb_we_o,
   output logic                  wb_exc_o,
   output logic                  illegal_o,
   output logic                  spurious_o,
   output logic                  busy_o
);
   localparam int unsigned NumIds = 2**IdWidth;
   localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);

   typedef enum logic {IDLE, ISSUE} state_e;

   typedef struct packed {
      logic [31:0]        instr;
      logic [2*XLEN-1:0]  rs;
      logic [1:0]         rs_valid;
      logic [IdWidth-1:0] id;
   } issue_req_t;

   state_e             state_q, state_d;
   issue_req_t         req_q, req_d;
   logic [IdWidth-1:0] next_id_q, next_id_d;
   logic [NumIds-1:0]  pending_q, pending_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               illegal_q, illegal_d;
   logic               spurious_q, spurious_d;
   logic               track_set, res_hit, res_clr;

   // FSM: next state, issue registers and handshake outputs
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      next_id_d     = next_id_q;
      illegal_d     = 1'b0;
      track_set     = 1'b0;
      instr_ready_o = 1'b0;
      xif.x_issue_valid = 1'b0;
      case (state_q)
         IDLE: begin
            // a still-pending next_id would alias two transactions
            instr_ready_o = (count_q < CntW'(MaxOutstanding)) && !pending_q[next_id_q];
            if (instr_valid_i && instr_ready_o) begin
               req_d.instr    = instr_i;
               req_d.rs       = {rs2_i, rs1_i};
               req_d.rs_valid = rs_valid_i;
               req_d.id       = next_id_q;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            xif.x_issue_valid = 1'b1;
            if (xif.x_issue_ready) begin
               state_d = IDLE;
               if (xif.x_issue_accept) begin
                  next_id_d = next_id_q + IdWidth'(1);
                  track_set = xif.x_issue_writeback;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign xif.x_issue_instr    = req_q.instr;
   assign xif.x_issue_rs       = req_q.rs;
   assign xif.x_issue_rs_valid = req_q.rs_valid;
   assign xif.x_issue_id       = req_q.id;

   // Result path: unmatched IDs are always consumed so they cannot stall the channel
   assign res_hit            = pending_q[xif.x_result_id];
   assign wb_valid_o         = xif.x_result_valid && res_hit;
   assign wb_data_o          = xif.x_result_data;
   assign wb_rd_o            = xif.x_result_rd;
   assign wb_we_o            = xif.x_result_we;
   assign wb_exc_o           = xif.x_result_exc;
   assign xif.x_result_ready = res_hit ? wb_ready_i : 1'b1;
   assign res_clr            = wb_valid_o && wb_ready_i;
   assign spurious_d         = xif.x_result_valid && !res_hit;

   // Set and clear never target the same ID, so both may apply in one cycle
   always_comb begin
      pending_d = pending_q;
      if (res_clr)   pending_d[xif.x_result_id] = 1'b0;
      if (track_set) pending_d[req_q.id]        = 1'b1;
      count_d = count_q + CntW'(track_set) - CntW'(res_clr);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         req_q      <= '0;
         next_id_q  <= '0;
         pending_q  <= '0;
         count_q    <= '0;
         illegal_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         next_id_q  <= next_id_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
         illegal_q  <= illegal_d;
         spurious_q <= spurious_d;
      end
   end

   assign illegal_o  = illegal_q;
   assign spurious_o = spurious_q;
   assign busy_o     = (state_q == ISSUE) || (|pending_q);
endmodule

// File: tb/tb_cvxif_offload_master.sv
// Directed bench for cvxif_offload_master: single offload, backpressure,
// reject, fill with out-of-order results, spurious results, reset mid-issue.
module tb_cvxif_offload_master;
   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0, rs1 = '0, rs2 = '0;
   logic [1:0]  rs_valid = '0;
   logic        wb_valid, wb_ready = 1'b0, wb_we, wb_exc;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        illegal, spurious, busy;
   int          total = 0, bad = 0;

   cvxif_offload_master_if #(.XLEN(32), .IdWidth(3)) xif ();

   cvxif_offload_master #(.XLEN(32), .IdWidth(3), .MaxOutstanding(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
      .rs1_i(rs1), .rs2_i(rs2), .rs_valid_i(rs_valid),
      .xif(xif.master),
      .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
      .wb_we_o(wb_we), .wb_exc_o(wb_exc),
      .illegal_o(illegal), .spurious_o(spurious), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      instr_valid = 0; instr = '0; rs1 = '0; rs2 = '0; rs_valid = '0; wb_ready = 0;
      xif.x_issue_ready = 0; xif.x_issue_accept = 0; xif.x_issue_writeback = 0;
      xif.x_result_valid = 0; xif.x_result_id = '0; xif.x_result_data = '0;
      xif.x_result_rd = '0; xif.x_result_we = 0; xif.x_result_exc = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 0;
      tick(); tick();
      rst_ni = 1;
      #1;
   endtask

   // Offer one instruction, hold the issue stalled for 'stall' cycles, then
   // complete the handshake with the given response.
   task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic acc, input logic wbk, input int stall,
                        input logic [2:0] exp_id, input string nm);
      instr_valid = 1; instr = ins; rs1 = a; rs2 = b; rs_valid = 2'b11;
      #1;
      total++;
      if (instr_ready !== 1'b1) begin bad++; $display("FAIL %s instr_ready got=%b exp=1", nm, instr_ready); end
      tick();
      instr_valid = 0; instr = '0; rs1 = '0; rs2 = '0; rs_valid = '0;
      for (int c = 0; c <= stall; c++) begin
         #1;
         total++;
         if (xif.x_issue_valid !== 1'b1 || xif.x_issue_instr !== ins ||
             xif.x_issue_rs !== {b, a} || xif.x_issue_rs_valid !== 2'b11 ||
             xif.x_issue_id !== exp_id || instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s issue_hold c=%0d got v=%b ins=%h rs=%h rsv=%b id=%0d rdy=%b exp v=1 ins=%h rs=%h rsv=11 id=%0d rdy=0",
                     nm, c, xif.x_issue_valid, xif.x_issue_instr, xif.x_issue_rs,
                     xif.x_issue_rs_valid, xif.x_issue_id, instr_ready, ins, {b, a}, exp_id);
         end
         if (c < stall) tick();
      end
      xif.x_issue_ready = 1; xif.x_issue_accept = acc; xif.x_issue_writeback = wbk;
      tick();
      xif.x_issue_ready = 0; xif.x_issue_accept = 0; xif.x_issue_writeback = 0;
      total++;
      if (xif.x_issue_valid !== 1'b0) begin bad++; $display("FAIL %s issue_drop got=%b exp=0", nm, xif.x_issue_valid); end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 0;
      #3;
      total++;
      if (xif.x_issue_valid !== 0 || wb_valid !== 0 || illegal !== 0 || spurious !== 0 || busy !== 0)
      begin bad++; $display("FAIL reset_outputs got v=%b wb=%b ill=%b sp=%b busy=%b exp all 0",
                            xif.x_issue_valid, wb_valid, illegal, spurious, busy); end
      tick(); tick();
      rst_ni = 1;
      #1;
      total++;
      if (instr_ready !== 1'b1 || xif.x_issue_id !== 3'd0)
      begin bad++; $display("FAIL reset_release got rdy=%b id=%0d exp rdy=1 id=0", instr_ready, xif.x_issue_id); end
   endtask

   task automatic test_single();
      do_reset();
      issue(32'h0420_00B3, 32'h0102_0304, 32'h0506_0708, 1, 1, 0, 3'd0, "single");
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
      xif.x_result_valid = 1; xif.x_result_id = 3'd0; xif.x_result_data = 32'h46;
      xif.x_result_rd = 5'd1; xif.x_result_we = 1; wb_ready = 1;
      #1;
      total++;
      if (wb_valid !== 1 || wb_data !== 32'h46 || wb_rd !== 5'd1 || wb_we !== 1 || wb_exc !== 0 ||
          xif.x_result_ready !== 1)
      begin bad++; $display("FAIL single_wb got v=%b d=%h rd=%0d we=%b exc=%b rr=%b exp v=1 d=46 rd=1 we=1 exc=0 rr=1",
                            wb_valid, wb_data, wb_rd, wb_we, wb_exc, xif.x_result_ready); end
      tick();
      idle_inputs();
      #1;
      total++;
      if (busy !== 0 || spurious !== 0) begin bad++; $display("FAIL single_clear got busy=%b sp=%b exp 0 0", busy, spurious); end
   endtask

   task automatic test_backpressure();
      do_reset();
      issue(32'h0420_00B3, 32'hAAAA_0001, 32'hBBBB_0002, 1, 0, 5, 3'd0, "bp");
      total++;
      if (busy !== 0) begin bad++; $display("FAIL bp_busy got=%b exp=0", busy); end
      issue(32'h0000_1111, 32'h1, 32'h2, 1, 0, 0, 3'd1, "bp_next");
   endtask

   task automatic test_reject();
      do_reset();
      issue(32'hDEAD_BEEF, 32'h3, 32'h4, 0, 1, 1, 3'd0, "reject");
      total++;
      if (illegal !== 1 || busy !== 0) begin bad++; $display("FAIL reject_pulse got ill=%b busy=%b exp 1 0", illegal, busy); end
      tick();
      total++;
      if (illegal !== 0) begin bad++; $display("FAIL reject_pulse_end got=%b exp=0", illegal); end
      issue(32'h0420_00B3, 32'h5, 32'h6, 1, 0, 0, 3'd0, "reject_retry");
      total++;
      if (illegal !== 0 || busy !== 0) begin bad++; $display("FAIL reject_retry_flags got ill=%b busy=%b exp 0 0", illegal, busy); end
   endtask

   task automatic test_fill();
      logic [2:0] order [4];
      order = '{3'd2, 3'd3, 3'd0, 3'd1};
      do_reset();
      for (int i = 0; i < 4; i++)
         issue(32'h0420_00B3 + i, 32'h10 + i, 32'h20 + i, 1, 1, 0, 3'(i), "fill");
      total++;
      if (instr_ready !== 0 || busy !== 1) begin bad++; $display("FAIL fill_full got rdy=%b busy=%b exp 0 1", instr_ready, busy); end
      for (int k = 0; k < 4; k++) begin
         xif.x_result_valid = 1; xif.x_result_id = order[k]; xif.x_result_data = 32'h100 + order[k];
         xif.x_result_rd = 5'(order[k] + 3); xif.x_result_we = 1; xif.x_result_exc = (order[k] == 3'd0);
         wb_ready = 1;
         #1;
         total++;
         if (wb_valid !== 1 || wb_data !== 32'h100 + order[k] || wb_rd !== 5'(order[k] + 3) ||
             wb_exc !== (order[k] == 3'd0))
         begin bad++; $display("FAIL fill_result id=%0d got v=%b d=%h rd=%0d exc=%b exp v=1 d=%h rd=%0d exc=%b",
                               order[k], wb_valid, wb_data, wb_rd, wb_exc, 32'h100 + order[k],
                               order[k] + 3, order[k] == 3'd0); end
         tick();
         idle_inputs();
         #1;
         if (k == 0) begin
            total++;
            if (instr_ready !== 1) begin bad++; $display("FAIL fill_ready_back got=%b exp=1", instr_ready); end
         end
      end
      total++;
      if (busy !== 0 || spurious !== 0) begin bad++; $display("FAIL fill_drain got busy=%b sp=%b exp 0 0", busy, spurious); end
      issue(32'h0000_0033, 32'h0, 32'h0, 1, 0, 0, 3'd4, "fill_id_next");
   endtask

   task automatic test_spurious();
      do_reset();
      xif.x_result_valid = 1; xif.x_result_id = 3'd5; xif.x_result_data = 32'h55;
      #1;
      total++;
      if (xif.x_result_ready !== 1 || wb_valid !== 0)
      begin bad++; $display("FAIL spur_drop got rr=%b wb=%b exp 1 0", xif.x_result_ready, wb_valid); end
      tick();
      idle_inputs();
      total++;
      if (spurious !== 1) begin bad++; $display("FAIL spur_pulse got=%b exp=1", spurious); end
      tick();
      total++;
      if (spurious !== 0) begin bad++; $display("FAIL spur_pulse_end got=%b exp=0", spurious); end
      issue(32'h0420_00B3, 32'h7, 32'h8, 1, 1, 0, 3'd0, "spur_issue");
      xif.x_result_valid = 1; xif.x_result_id = 3'd0; xif.x_result_data = 32'h77; wb_ready = 0;
      #1;
      total++;
      if (xif.x_result_ready !== 0 || wb_valid !== 1)
      begin bad++; $display("FAIL spur_hold got rr=%b wb=%b exp 0 1", xif.x_result_ready, wb_valid); end
      tick(); tick();
      total++;
      if (busy !== 1 || wb_valid !== 1 || spurious !== 0)
      begin bad++; $display("FAIL spur_held got busy=%b wb=%b sp=%b exp 1 1 0", busy, wb_valid, spurious); end
      wb_ready = 1;
      tick();
      idle_inputs();
      #1;
      total++;
      if (busy !== 0) begin bad++; $display("FAIL spur_release got busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      issue(32'h0420_00B3, 32'h9, 32'hA, 1, 1, 0, 3'd0, "rmid_first");
      instr_valid = 1; instr = 32'h0420_00B3; rs1 = 32'hB; rs2 = 32'hC; rs_valid = 2'b11;
      tick();
      instr_valid = 0;
      total++;
      if (xif.x_issue_valid !== 1 || xif.x_issue_id !== 3'd1)
      begin bad++; $display("FAIL rmid_inflight got v=%b id=%0d exp 1 1", xif.x_issue_valid, xif.x_issue_id); end
      rst_ni = 0;
      #1;
      total++;
      if (xif.x_issue_valid !== 0 || busy !== 0 || illegal !== 0)
      begin bad++; $display("FAIL rmid_async got v=%b busy=%b ill=%b exp 0 0 0", xif.x_issue_valid, busy, illegal); end
      tick();
      rst_ni = 1;
      #1;
      total++;
      if (illegal !== 0 || spurious !== 0 || busy !== 0)
      begin bad++; $display("FAIL rmid_after got ill=%b sp=%b busy=%b exp 0 0 0", illegal, spurious, busy); end
      issue(32'h0420_00B3, 32'hD, 32'hE, 1, 0, 0, 3'd0, "rmid_id0");
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_backpressure();
      test_reject();
      test_fill();
      test_spurious();
      test_reset_mid_issue();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
